// File: rtl/alu_driver.sv
// alu_driver: initiator for a 4-bit ALU port. It takes single 4-bit operations
// and 8-bit adds over a valid/ready request channel, drives the ALU one pass at
// a time, and returns the result and flags over a valid/ready response channel.
// The ALU has no carry-in, so an 8-bit add takes a low pass and a high pass,
// plus a fix-up pass that adds 1 to the high nibble when the low pass carried.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; ALU inputs parked at 0
// EXEC  | single 4-bit op in flight
// LO    | wide add, low nibble pass
// HI    | wide add, high nibble pass
// FIX   | wide add, +1 on the high nibble to fold in the low-pass carry
// RSP   | response presented, held stable until the consumer takes it
module alu_driver #(
  parameter int unsigned ALU_LAT = 0
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_req_valid,
  output logic       out_req_ready,
  input  logic       in_req_wide,
  input  logic [2:0] in_req_op,
  input  logic [7:0] in_req_a,
  input  logic [7:0] in_req_b,
  output logic       out_rsp_valid,
  input  logic       in_rsp_ready,
  output logic [7:0] out_rsp_result,
  output logic       out_rsp_carry,
  output logic       out_rsp_overflow,
  output logic       out_rsp_zero,
  output logic [2:0] out_alu_func,
  output logic [3:0] out_alu_a,
  output logic [3:0] out_alu_b,
  input  logic [3:0] in_alu_result,
  input  logic       in_alu_carry,
  input  logic       in_alu_overflow,
  input  logic       in_alu_zero
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_FIX  = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  localparam logic [2:0] LAT_TC = 3'(ALU_LAT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic       r_wide;
  logic [2:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [3:0] r_lo;
  logic [3:0] r_hi;
  logic       r_c0;
  logic       r_c1;
  logic [7:0] r_result;
  logic       r_carry;
  logic       r_ovf;
  logic       r_zero;

  logic       w_in_pass;
  logic       w_pass_done;
  logic       w_accept;
  logic [7:0] w_wide_res;
  logic       w_wide_ovf;

  assign w_in_pass   = (r_state == S_EXEC) || (r_state == S_LO) ||
                       (r_state == S_HI)   || (r_state == S_FIX);
  assign w_pass_done = w_in_pass && (r_cnt == LAT_TC);
  assign w_accept    = in_req_valid && out_req_ready;

  // The high nibble comes straight from the ALU on the pass that finishes a wide add.
  assign w_wide_res  = {in_alu_result, r_lo};
  assign w_wide_ovf  = (r_a[7] == r_b[7]) && (w_wide_res[7] != r_a[7]);

  assign out_rsp_result   = r_result;
  assign out_rsp_carry    = r_carry;
  assign out_rsp_overflow = r_ovf;
  assign out_rsp_zero     = r_zero;

  // State register.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Pass timer: counts cycles the ALU inputs have been held, clears when a pass ends.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n)                    r_cnt <= '0;
    else if (w_pass_done || !w_in_pass) r_cnt <= '0;
    else                              r_cnt <= r_cnt + 3'd1;
  end

  // Request capture; later changes on the request bus have no effect.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_wide <= 1'b0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (w_accept) begin
      r_wide <= in_req_wide;
      r_op   <= in_req_op;
      r_a    <= in_req_a;
      r_b    <= in_req_b;
    end
  end

  // Sample ALU outputs at the end of each pass; build the response on the last one.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_lo     <= '0;
      r_hi     <= '0;
      r_c0     <= 1'b0;
      r_c1     <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_pass_done) begin
      case (r_state)
        S_EXEC: begin
          r_result <= {4'b0000, in_alu_result};
          r_carry  <= in_alu_carry;
          r_ovf    <= in_alu_overflow;
          r_zero   <= in_alu_zero;
        end
        S_LO: begin
          r_lo <= in_alu_result;
          r_c0 <= in_alu_carry;
        end
        S_HI: begin
          r_hi <= in_alu_result;
          r_c1 <= in_alu_carry;
          if (!r_c0) begin
            r_result <= w_wide_res;
            r_carry  <= in_alu_carry;
            r_ovf    <= w_wide_ovf;
            r_zero   <= (w_wide_res == 8'h00);
          end
        end
        S_FIX: begin
          r_hi     <= in_alu_result;
          r_result <= w_wide_res;
          r_carry  <= r_c1 | in_alu_carry;
          r_ovf    <= w_wide_ovf;
          r_zero   <= (w_wide_res == 8'h00);
        end
        default: ;
      endcase
    end
  end

  // Next state, handshakes and ALU drive.
  always_comb begin
    w_state_nxt   = r_state;
    out_req_ready = 1'b0;
    out_rsp_valid = 1'b0;
    out_alu_func  = 3'b000;
    out_alu_a     = 4'h0;
    out_alu_b     = 4'h0;
    case (r_state)
      S_IDLE: begin
        out_req_ready = 1'b1;
        if (in_req_valid) w_state_nxt = in_req_wide ? S_LO : S_EXEC;
      end
      S_EXEC: begin
        out_alu_func = r_op;
        out_alu_a    = r_a[3:0];
        out_alu_b    = r_b[3:0];
        if (w_pass_done) w_state_nxt = S_RSP;
      end
      S_LO: begin
        out_alu_a = r_a[3:0];
        out_alu_b = r_b[3:0];
        if (w_pass_done) w_state_nxt = S_HI;
      end
      S_HI: begin
        out_alu_a = r_a[7:4];
        out_alu_b = r_b[7:4];
        if (w_pass_done) w_state_nxt = r_c0 ? S_FIX : S_RSP;
      end
      S_FIX: begin
        out_alu_a = r_hi;
        out_alu_b = 4'h1;
        if (w_pass_done) w_state_nxt = S_RSP;
      end
      S_RSP: begin
        out_rsp_valid = 1'b1;
        if (in_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: two instances (ALU_LAT=0 and ALU_LAT=2), each attached
// to a stand-in 4-bit ALU whose outputs reflect its inputs from ALU_LAT cycles
// earlier. Expected responses come from plain 8-bit arithmetic.
module tb_alu_driver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       req_valid [2];
  logic       req_wide  [2];
  logic [2:0] req_op    [2];
  logic [7:0] req_a     [2];
  logic [7:0] req_b     [2];
  logic       rsp_ready [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_res   [2];
  logic       rsp_c     [2];
  logic       rsp_v     [2];
  logic       rsp_z     [2];
  logic [2:0] alu_f     [2];
  logic [3:0] alu_a     [2];
  logic [3:0] alu_b     [2];
  logic [3:0] alu_r     [2];
  logic       alu_c     [2];
  logic       alu_v     [2];
  logic       alu_z     [2];

  int checks = 0;
  int errors = 0;

  // Stand-in ALU: returns {zero, overflow, carry, result[3:0]}.
  function automatic logic [6:0] alu_fn(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; s = '0;
    case (f)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
      3'd2: r = a | b;
      3'd3: r = a & b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = {a[2:0], 1'b0};
      default: r = b;
    endcase
    return {(r == 4'h0), v, c, r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned LAT = (g == 1) ? 2 : 0;
    alu_driver #(.ALU_LAT(LAT)) u_dut (
      .in_clk(clk), .in_rst_n(rst_n),
      .in_req_valid(req_valid[g]), .out_req_ready(req_ready[g]),
      .in_req_wide(req_wide[g]), .in_req_op(req_op[g]),
      .in_req_a(req_a[g]), .in_req_b(req_b[g]),
      .out_rsp_valid(rsp_valid[g]), .in_rsp_ready(rsp_ready[g]),
      .out_rsp_result(rsp_res[g]), .out_rsp_carry(rsp_c[g]),
      .out_rsp_overflow(rsp_v[g]), .out_rsp_zero(rsp_z[g]),
      .out_alu_func(alu_f[g]), .out_alu_a(alu_a[g]), .out_alu_b(alu_b[g]),
      .in_alu_result(alu_r[g]), .in_alu_carry(alu_c[g]),
      .in_alu_overflow(alu_v[g]), .in_alu_zero(alu_z[g])
    );
    logic [10:0] w_cur;
    logic [10:0] hist [0:7];
    logic [10:0] w_sel;
    logic [6:0]  w_o;
    assign w_cur = {alu_f[g], alu_a[g], alu_b[g]};
    always @(posedge clk) begin
      for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= w_cur;
    end
    assign w_sel = (LAT == 0) ? w_cur : hist[LAT-1];
    assign w_o   = alu_fn(w_sel[10:8], w_sel[7:4], w_sel[3:0]);
    assign alu_r[g] = w_o[3:0];
    assign alu_c[g] = w_o[4];
    assign alu_v[g] = w_o[5];
    assign alu_z[g] = w_o[6];
  end

  // One request/response transaction with inline checks of latency, ALU drive sequence and response.
  task automatic run_op(input int idx, input bit wide, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b, input int hold);
    int lat, passes, n;
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];
    logic [7:0] e_res;
    logic e_c, e_v, e_z;
    logic [8:0] sum;
    logic [6:0] f;
    logic [3:0] h;
    bit ready_bad, seq_bad;
    lat = (idx == 1) ? 2 : 0;
    if (wide) begin
      sum   = {1'b0, a} + {1'b0, b};
      e_res = sum[7:0];
      e_c   = sum[8];
      e_v   = (a[7] == b[7]) && (e_res[7] != a[7]);
      e_z   = (e_res == 8'h00);
      passes = (({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15) ? 3 : 2;
      h = a[7:4] + b[7:4];
      for (int k = 0; k <= lat; k++) exp_q.push_back({3'd0, a[3:0], b[3:0]});
      for (int k = 0; k <= lat; k++) exp_q.push_back({3'd0, a[7:4], b[7:4]});
      if (passes == 3) for (int k = 0; k <= lat; k++) exp_q.push_back({3'd0, h, 4'h1});
    end else begin
      f = alu_fn(op, a[3:0], b[3:0]);
      e_res = {4'h0, f[3:0]};
      e_c = f[4]; e_v = f[5]; e_z = f[6];
      passes = 1;
      for (int k = 0; k <= lat; k++) exp_q.push_back({op, a[3:0], b[3:0]});
    end

    @(negedge clk);
    req_valid[idx] = 1'b1; req_wide[idx] = wide; req_op[idx] = op;
    req_a[idx] = a; req_b[idx] = b;
    checks++;
    if (req_ready[idx] !== 1'b1) begin errors++; $display("FAIL accept_ready idx=%0d got=%b exp=1", idx, req_ready[idx]); end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0; req_wide[idx] = ~wide; req_op[idx] = 3'($urandom);
    req_a[idx] = 8'($urandom); req_b[idx] = 8'($urandom);

    n = 0; ready_bad = 0;
    while (n <= 100) begin
      if (rsp_valid[idx] === 1'b1) break;
      got_q.push_back({alu_f[idx], alu_a[idx], alu_b[idx]});
      if (req_ready[idx] !== 1'b0) ready_bad = 1;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n > 100) begin
      errors++; $display("FAIL rsp_timeout idx=%0d no response within 100 cycles", idx);
      return;
    end
    checks++;
    if (n != passes * (lat + 1)) begin errors++; $display("FAIL latency idx=%0d a=%h b=%h got=%0d exp=%0d", idx, a, b, n, passes * (lat + 1)); end
    seq_bad = (got_q.size() != exp_q.size());
    if (!seq_bad) foreach (exp_q[k]) if (got_q[k] !== exp_q[k]) seq_bad = 1;
    checks++;
    if (seq_bad) begin errors++; $display("FAIL alu_drive_seq idx=%0d a=%h b=%h got_n=%0d exp_n=%0d first_got=%h first_exp=%h", idx, a, b, got_q.size(), exp_q.size(), got_q.size() ? got_q[0] : 11'h0, exp_q[0]); end
    checks++;
    if (ready_bad) begin errors++; $display("FAIL busy_ready idx=%0d got=1 exp=0 while busy", idx); end

    for (int k = 0; k <= hold; k++) begin
      checks++;
      if (rsp_valid[idx] !== 1'b1 || rsp_res[idx] !== e_res || rsp_c[idx] !== e_c ||
          rsp_v[idx] !== e_v || rsp_z[idx] !== e_z || req_ready[idx] !== 1'b0) begin
        errors++;
        $display("FAIL rsp idx=%0d cyc=%0d a=%h b=%h got v=%b res=%h c=%b o=%b z=%b rdy=%b exp v=1 res=%h c=%b o=%b z=%b rdy=0",
                 idx, k, a, b, rsp_valid[idx], rsp_res[idx], rsp_c[idx], rsp_v[idx], rsp_z[idx], req_ready[idx], e_res, e_c, e_v, e_z);
      end
      if (k < hold) begin @(posedge clk); #1; end
    end
    @(negedge clk); rsp_ready[idx] = 1'b1;
    @(posedge clk); #1; rsp_ready[idx] = 1'b0;
    checks++;
    if (rsp_valid[idx] !== 1'b0 || req_ready[idx] !== 1'b1) begin
      errors++; $display("FAIL rsp_release idx=%0d got valid=%b ready=%b exp valid=0 ready=1", idx, rsp_valid[idx], req_ready[idx]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_wide[i] = 0; req_op[i] = 0; req_a[i] = 0; req_b[i] = 0; rsp_ready[i] = 0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rsp_valid[i] !== 1'b0 || rsp_res[i] !== 8'h00 || rsp_c[i] !== 1'b0 || rsp_v[i] !== 1'b0 ||
          rsp_z[i] !== 1'b0 || alu_f[i] !== 3'd0 || alu_a[i] !== 4'h0 || alu_b[i] !== 4'h0) begin
        errors++; $display("FAIL reset_state idx=%0d got v=%b res=%h alu=%h/%h/%h exp all 0", idx_str(i), rsp_valid[i], rsp_res[i], alu_f[i], alu_a[i], alu_b[i]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req_ready[i] !== 1'b1) begin errors++; $display("FAIL reset_ready idx=%0d got=%b exp=1", i, req_ready[i]); end
    end
  endtask

  function automatic int idx_str(input int i);
    return i;
  endfunction

  task automatic test_single();
    run_op(0, 0, 3'b011, 8'h0C, 8'h0A, 0);
    run_op(0, 0, 3'b000, 8'h07, 8'h01, 0);
    run_op(0, 0, 3'b001, 8'h03, 8'h05, 1);
    run_op(1, 0, 3'b100, 8'h05, 8'h05, 0);
  endtask

  task automatic test_wide();
    run_op(0, 1, 3'b111, 8'h12, 8'h34, 0);
    run_op(0, 1, 3'b000, 8'h0F, 8'h01, 0);
    run_op(0, 1, 3'b000, 8'hFF, 8'h01, 0);
    run_op(0, 1, 3'b000, 8'h80, 8'h80, 0);
    run_op(0, 1, 3'b000, 8'h7F, 8'h01, 0);
  endtask

  task automatic test_backpressure();
    run_op(1, 1, 3'b000, 8'h0F, 8'h01, 5);
    run_op(1, 1, 3'b000, 8'h12, 8'h34, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(i % 2, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) run_op(0, i[0], 3'($urandom), 8'($urandom), 8'($urandom), 0);
  endtask

  task automatic test_reset_mid_op();
    bit stale;
    @(negedge clk);
    req_valid[1] = 1'b1; req_wide[1] = 1'b1; req_op[1] = 3'd0; req_a[1] = 8'h5F; req_b[1] = 8'h31;
    @(posedge clk); #1; req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    checks++;
    if (alu_a[1] !== 4'h5 || alu_b[1] !== 4'h3) begin errors++; $display("FAIL hi_pass_drive got a=%h b=%h exp a=5 b=3", alu_a[1], alu_b[1]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (alu_f[1] !== 3'd0 || alu_a[1] !== 4'h0 || alu_b[1] !== 4'h0 || rsp_valid[1] !== 1'b0) begin
      errors++; $display("FAIL async_reset got alu=%h/%h/%h v=%b exp 0/0/0 v=0", alu_f[1], alu_a[1], alu_b[1], rsp_valid[1]);
    end
    #7 rst_n = 1'b1;
    stale = 0;
    rsp_ready[1] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) stale = 1;
    end
    rsp_ready[1] = 1'b0;
    checks++;
    if (stale) begin errors++; $display("FAIL post_reset got stale response or ready low, exp valid=0 ready=1"); end
    run_op(1, 1, 3'b000, 8'h5F, 8'h31, 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wide();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
- Initiator side of the 4-bit ALU port (func, a, b in; result, carry, overflow, zero out).
- Accepts operation requests over a valid/ready handshake and drives the ALU.
- Samples the ALU flags and returns them over a valid/ready response channel.
- Also runs an 8-bit add as a sequence of 4-bit ALU passes, because the ALU has no carry-in.

Parameters:
ALU_LAT, 0, extra cycles to wait after driving ALU inputs before sampling outputs (0 = combinational ALU); legal range 0..7.

Ports:
in_clk  input  1  clock; all state updates on rising edge
in_rst_n  input  1  reset, asynchronous, active-low
in_req_valid  input  1  request present
out_req_ready  output  1  block can accept a request
in_req_wide  input  1  1 = 8-bit add (in_req_op ignored); 0 = single 4-bit op
in_req_op  input  3  ALU function code for single ops (000..111)
in_req_a  input  8  operand A (single op uses [3:0])
in_req_b  input  8  operand B (single op uses [3:0])
out_rsp_valid  output  1  response present
in_rsp_ready  input  1  consumer accepts response
out_rsp_result  output  8  result
out_rsp_carry  output  1  carry out
out_rsp_overflow  output  1  signed overflow
out_rsp_zero  output  1  result == 0
out_alu_func  output  3  to ALU
out_alu_a  output  4  to ALU
out_alu_b  output  4  to ALU
in_alu_result  input  4  from ALU
in_alu_carry  input  1  from ALU
in_alu_overflow  input  1  from ALU
in_alu_zero  input  1  from ALU

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (async, immediate):
  - state IDLE, wait counter 0, all captured operands and partial results 0.
  - out_rsp_valid=0, out_rsp_* all 0.
  - out_alu_func/a/b=0, out_req_ready=1 once released.
- States: IDLE, EXEC, LO, HI, FIX, RSP.
- IDLE:
  - out_req_ready=1 only in IDLE; ALU inputs driven 0.
  - On in_req_valid & out_req_ready: capture wide, op, a, b.
  - Go to EXEC (wide=0) or LO (wide=1).
- Pass timing, common to EXEC/LO/HI/FIX:
  - ALU inputs held constant for ALU_LAT+1 cycles.
  - ALU outputs sampled at the rising edge ending the last cycle; the counter then clears.
- EXEC:
  - Drive func=op, a=A[3:0], b=B[3:0].
  - Sample to result={4'b0, in_alu_result}; carry, overflow and zero come straight from the ALU.
  - Go to RSP.
- LO:
  - Drive func=000, a=A[3:0], b=B[3:0].
  - Store lo=in_alu_result, c0=in_alu_carry, then go to HI.
- HI:
  - Drive func=000, a=A[7:4], b=B[7:4].
  - Store hi, c1.
  - Go to FIX if c0=1, else RSP.
- FIX:
  - Drive func=000, a=hi, b=4'b0001.
  - Store hi=in_alu_result, c2=in_alu_carry, then go to RSP.
- Wide result rules:
  - result={hi,lo}; carry=c1|c2 (c2=0 if FIX skipped).
  - overflow=(A[7]==B[7]) && (result[7]!=A[7]); zero=(result==8'h00).
  - ALU overflow/zero inputs are ignored in wide mode.
- RSP:
  - out_rsp_valid=1; all out_rsp_* stable while valid & !ready.
  - On in_rsp_ready: go to IDLE, valid drops the next cycle.
  - No new request is accepted until back in IDLE (no overlap, no bypass).
- Latency:
  - Edges from the accept edge to the edge raising out_rsp_valid = passes*(ALU_LAT+1).
  - passes = 1 (single), 2 (wide, c0=0), 3 (wide, c0=1).
- Reset asserted mid-operation: request and partial results discarded, no response emitted.
- Request fields change after accept: no effect (captured copy used).

Test Plan:
- ALU_LAT=0, single op=011, A=0x0C, B=0x0A -> one pass; rsp result=0x08, carry=0, overflow=0, zero=0; out_rsp_valid high 1 cycle after the EXEC cycle.
- Wide A=0x12, B=0x34 -> passes LO,HI only (FIX skipped); result=0x46, carry=0, overflow=0, zero=0; rsp_valid 2 edges after accept.
- Wide A=0x0F, B=0x01 -> LO gives 0x0, c0=1; HI gives 0x0; FIX 0x0+1=0x1; result=0x10, carry=0, overflow=0; out_alu_a=0x0, out_alu_b=0x1 during FIX.
- Wide A=0xFF, B=0x01 -> result=0x00, carry=1 (from FIX), overflow=0, zero=1; wide A=0x80, B=0x80 -> result=0x00, carry=1, overflow=1, zero=1.
- ALU_LAT=2, wide A=0x0F, B=0x01 with in_rsp_ready low for 5 cycles:
  - ALU inputs held 3 cycles per pass; rsp_valid 9 edges after accept.
  - Response held stable; out_req_ready=0 until the handshake, 1 the next cycle.
- Drop in_rst_n mid-HI pass (async, not clock-aligned) -> same cycle: out_alu_*=0, out_rsp_valid=0; after release, out_req_ready=1 and no stale response ever appears.
